// File: rtl/sbox_inv_ghpc_anf_pipeline_d1_if.sv
// Shared-nibble stream between the inverse round pipeline and the masked InvS gadget.
// The master drives the i_* side; the gadget (slave) returns the o_* side.
interface sbox_inv_ghpc_anf_pipeline_d1_if;
    logic       i_valid;
    logic [3:0] i_x_s0;
    logic [3:0] i_x_s1;
    logic [3:0] i_fresh;
    logic       o_valid;
    logic [3:0] o_y_s0;
    logic [3:0] o_y_s1;

    modport master (
        output i_valid, i_x_s0, i_x_s1, i_fresh,
        input  o_valid, o_y_s0, o_y_s1
    );

    modport slave (
        input  i_valid, i_x_s0, i_x_s1, i_fresh,
        output o_valid, o_y_s0, o_y_s1
    );
endinterface

// File: rtl/sbox_inv_ghpc_anf_pipeline_d1.sv
// First-order GHPC masked inverse Skinny-64 S-box.
// Share 0 expands into a 16-entry masked table; registered share 1 then selects one entry.
module sbox_inv_ghpc_anf_pipeline_d1 #(
    parameter int unsigned low_latency = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    sbox_inv_ghpc_anf_pipeline_d1_if.slave       bus
);

    // InvS as algebraic normal form over x[3:0].
    function automatic logic [3:0] inv_s_anf(input logic [3:0] x);
        logic [3:0] y;
        y[0] = 1'b1 ^ x[0] ^ x[1] ^ (x[0] & x[1]) ^ x[2] ^ (x[0] & x[2])
             ^ (x[1] & x[3]) ^ (x[0] & x[2] & x[3]) ^ (x[1] & x[2] & x[3]);
        y[1] = 1'b1 ^ x[0] ^ x[2] ^ x[3] ^ (x[2] & x[3]);
        y[2] = x[0] ^ x[1] ^ x[2] ^ (x[0] & x[3]) ^ (x[2] & x[3]);
        y[3] = (x[0] & x[1]) ^ x[2] ^ (x[1] & x[2]) ^ x[3] ^ (x[0] & x[3])
             ^ (x[1] & x[3]) ^ (x[1] & x[2] & x[3]);
        return y;
    endfunction

    logic [3:0] w_x0;
    logic [3:0] w_x1;
    logic [3:0] w_r;
    logic       w_v0;

    generate
        if (low_latency == 0) begin : g_in_stage
            logic [3:0] r_x0;
            logic [3:0] r_x1;
            logic [3:0] r_r;
            logic       r_v0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_x0 <= 4'h0;
                    r_x1 <= 4'h0;
                    r_r  <= 4'h0;
                    r_v0 <= 1'b0;
                end else begin
                    r_x0 <= bus.i_x_s0;
                    r_x1 <= bus.i_x_s1;
                    r_r  <= bus.i_fresh;
                    r_v0 <= bus.i_valid;
                end
            end

            assign w_x0 = r_x0;
            assign w_x1 = r_x1;
            assign w_r  = r_r;
            assign w_v0 = r_v0;
        end else begin : g_no_in_stage
            assign w_x0 = bus.i_x_s0;
            assign w_x1 = bus.i_x_s1;
            assign w_r  = bus.i_fresh;
            assign w_v0 = bus.i_valid;
        end
    endgenerate

    // Table entries see only share 0 and fresh mask; share 1 is kept apart until after the register.
    logic [3:0] w_t_next [16];
    logic [3:0] r_t      [16];
    logic [3:0] r_s;
    logic [3:0] r_r;
    logic       r_v1;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_table
            localparam logic [3:0] V = 4'(gi);
            assign w_t_next[gi] = inv_s_anf(w_x0 ^ V) ^ w_r;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < 16; v++) begin
                r_t[v] <= 4'h0;
            end
            r_s  <= 4'h0;
            r_r  <= 4'h0;
            r_v1 <= 1'b0;
        end else begin
            for (int v = 0; v < 16; v++) begin
                r_t[v] <= w_t_next[v];
            end
            r_s  <= w_x1;
            r_r  <= w_r;
            r_v1 <= w_v0;
        end
    end

    logic [3:0] r_y_s0;
    logic [3:0] r_y_s1;
    logic       r_vo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_s0 <= 4'h0;
            r_y_s1 <= 4'h0;
            r_vo   <= 1'b0;
        end else begin
            r_y_s0 <= r_t[r_s];
            r_y_s1 <= r_r;
            r_vo   <= r_v1;
        end
    end

    assign bus.o_valid = r_vo;
    assign bus.o_y_s0  = r_y_s0;
    assign bus.o_y_s1  = r_y_s1;

endmodule

// File: tb/tb_sbox_inv_ghpc_anf_pipeline_d1.sv
// Directed bench for the masked InvS gadget in both latency configurations.
// Expected values come from the plain InvS/S lookup tables below.
module tb_sbox_inv_ghpc_anf_pipeline_d1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sbox_inv_ghpc_anf_pipeline_d1_if bus0 ();
    sbox_inv_ghpc_anf_pipeline_d1_if bus1 ();

    sbox_inv_ghpc_anf_pipeline_d1 #(.low_latency(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    sbox_inv_ghpc_anf_pipeline_d1 #(.low_latency(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    logic [3:0] inv_s_tbl [16] = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
                                   4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF};
    logic [3:0] fwd_s_tbl [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                   4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] f);
        bus0.i_valid = v;
        bus0.i_x_s0  = s0;
        bus0.i_x_s1  = s1;
        bus0.i_fresh = f;
    endtask

    task automatic drive1(input logic v, input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] f);
        bus1.i_valid = v;
        bus1.i_x_s0  = s0;
        bus1.i_x_s1  = s1;
        bus1.i_fresh = f;
    endtask

    logic [3:0] ex_x [64];
    logic [3:0] ex_f [64];
    logic [3:0] x, s0, f, y;
    logic       gap_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] gap_x [6] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
    int         run_len;

    initial begin
        rst = 1'b1;
        drive0(1'b0, 4'h0, 4'h0, 4'h0);
        drive1(1'b0, 4'h0, 4'h0, 4'h0);
        #1;
        check("reset_valid", {7'd0, bus0.o_valid}, 8'h00);
        check("reset_y", {bus0.o_y_s1, bus0.o_y_s0}, 8'h00);
        step();
        step();
        rst = 1'b0;
        step();

        // Single transaction X=0, latency 3.
        drive0(1'b1, 4'h5, 4'h5, 4'hA);
        step();
        drive0(1'b0, 4'h0, 4'h0, 4'h0);
        step();
        check("single_early_valid", {7'd0, bus0.o_valid}, 8'h00);
        step();
        check("single_valid", {7'd0, bus0.o_valid}, 8'h01);
        check("single_y_s0", {4'h0, bus0.o_y_s0}, 8'h09);
        check("single_y_s1", {4'h0, bus0.o_y_s1}, 8'h0A);
        $display("txn single: X=0 Fresh=A -> Y_s0=%h Y_s1=%h", bus0.o_y_s0, bus0.o_y_s1);
        step();
        check("single_after_valid", {7'd0, bus0.o_valid}, 8'h00);
        step();
        step();

        // Exhaustive back-to-back stream, four random splits per X.
        run_len = 0;
        for (int c = 0; c < 68; c++) begin
            if (c < 64) begin
                x  = 4'(c / 4);
                s0 = 4'($urandom_range(0, 15));
                f  = 4'($urandom_range(0, 15));
                ex_x[c] = x;
                ex_f[c] = f;
                drive0(1'b1, s0, s0 ^ x, f);
            end else begin
                drive0(1'b0, 4'h0, 4'h0, 4'h0);
            end
            step();
            if (c < 2 || c >= 66) begin
                check("stream_idle_valid", {7'd0, bus0.o_valid}, 8'h00);
            end else begin
                y = bus0.o_y_s0 ^ bus0.o_y_s1;
                if (bus0.o_valid) run_len++;
                check("stream_valid", {7'd0, bus0.o_valid}, 8'h01);
                check("stream_invs", {4'h0, y}, {4'h0, inv_s_tbl[ex_x[c-2]]});
                check("stream_y_s1", {4'h0, bus0.o_y_s1}, {4'h0, ex_f[c-2]});
                $display("txn stream %0d: X=%h -> Y=%h", c - 2, ex_x[c-2], y);
            end
        end
        check("stream_run_len", 8'(run_len), 8'd64);

        // Round trip X=9 through InvS and then the forward S-box.
        drive0(1'b1, 4'hC, 4'h5, 4'h6);
        step();
        drive0(1'b0, 4'h0, 4'h0, 4'h0);
        step();
        step();
        y = bus0.o_y_s0 ^ bus0.o_y_s1;
        check("roundtrip_inv", {4'h0, y}, 8'h02);
        check("roundtrip_fwd", {4'h0, fwd_s_tbl[y]}, 8'h09);
        $display("txn roundtrip: X=9 -> InvS=%h -> S=%h", y, fwd_s_tbl[y]);
        step();

        // Outputs still track data when in_valid is low; gives non-zero state before reset.
        drive0(1'b0, 4'h3, 4'h0, 4'h5);
        step();
        step();
        step();
        check("dontcare_y_s0", {4'h0, bus0.o_y_s0}, 8'h0D);
        check("dontcare_y_s1", {4'h0, bus0.o_y_s1}, 8'h05);

        // Reset mid-flight after the second of three valid nibbles.
        drive0(1'b1, 4'h1, 4'h2, 4'h7);
        step();
        drive0(1'b1, 4'h4, 4'h8, 4'h9);
        step();
        drive0(1'b1, 4'h6, 4'h3, 4'hE);
        rst = 1'b1;
        #1;
        check("rst_async_valid", {7'd0, bus0.o_valid}, 8'h00);
        check("rst_async_y", {bus0.o_y_s1, bus0.o_y_s0}, 8'h00);
        $display("txn reset: asserted mid-flight");
        step();
        drive0(1'b0, 4'h0, 4'h0, 4'h0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_rst_no_valid", {7'd0, bus0.o_valid}, 8'h00);
        end
        drive0(1'b1, 4'hF, 4'h0, 4'h0);
        step();
        drive0(1'b0, 4'h0, 4'h0, 4'h0);
        step();
        step();
        check("post_rst_valid", {7'd0, bus0.o_valid}, 8'h01);
        check("post_rst_y_s0", {4'h0, bus0.o_y_s0}, 8'h0F);
        check("post_rst_y_s1", {4'h0, bus0.o_y_s1}, 8'h00);
        $display("txn post-reset: X=F -> Y_s0=%h Y_s1=%h", bus0.o_y_s0, bus0.o_y_s1);
        step();

        // Low-latency instance: exactly two edges.
        drive1(1'b1, 4'h0, 4'h4, 4'h3);
        step();
        drive1(1'b0, 4'h0, 4'h0, 4'h0);
        check("ll_early_valid", {7'd0, bus1.o_valid}, 8'h00);
        step();
        check("ll_valid", {7'd0, bus1.o_valid}, 8'h01);
        check("ll_y_s0", {4'h0, bus1.o_y_s0}, 8'h0F);
        check("ll_y_s1", {4'h0, bus1.o_y_s1}, 8'h03);
        $display("txn low-latency: X=4 Fresh=3 -> Y_s0=%h Y_s1=%h", bus1.o_y_s0, bus1.o_y_s1);
        step();
        check("ll_after_valid", {7'd0, bus1.o_valid}, 8'h00);

        // Alternating in_valid: pattern must reappear three cycles later.
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive0(gap_v[c], gap_x[c], 4'h0, 4'h0);
            else       drive0(1'b0, 4'h0, 4'h0, 4'h0);
            step();
            if (c >= 2) begin
                check("gap_valid", {7'd0, bus0.o_valid}, {7'd0, gap_v[c-2]});
                if (gap_v[c-2]) begin
                    check("gap_result", {4'h0, bus0.o_y_s0 ^ bus0.o_y_s1}, {4'h0, inv_s_tbl[gap_x[c-2]]});
                    $display("txn gap: X=%h -> Y=%h", gap_x[c-2], bus0.o_y_s0 ^ bus0.o_y_s1);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
